iqmap_qpsk: RTL and testbench

QPSK transmit mapper, the inverse of iqdemap_qpsk. It accepts 128-bit payload words, serializes each into 64 two-bit symbols, LSB pair first, and emits one signed I/Q sample pair per enabled clock. A one-word holding buffer lets a second word be accepted mid-burst, so back-to-back words stream with no gap. It sits between the frame writer and the DAC/channel model, and its output feeds iqdemap_qpsk in loopback benches.

---
 rtl/qpsk_pkg.sv | 21 ++
 rtl/qpsk_sym2iq.sv | 17 +
 rtl/iqmap_qpsk.sv | 173 +++++++++++++++++
 tb/tb_iqmap_qpsk.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_pkg.sv
// Types and constants shared by the QPSK mapper and demapper.
package qpsk_pkg;

  localparam int SYMS_PER_WORD = 64;
  localparam int WORD_W        = 128;

  localparam logic [1:0] PRE_SYM_EVEN = 2'b00;
  localparam logic [1:0] PRE_SYM_ODD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // Preamble alternates 00,11,00,... starting with 00 on an even index.
  function automatic logic [1:0] pre_sym(input logic odd);
    return odd ? PRE_SYM_ODD : PRE_SYM_EVEN;
  endfunction

endpackage

// File: rtl/qpsk_sym2iq.sv
// Combinational QPSK constellation map: bit 1 -> I sign, bit 0 -> Q sign.
module qpsk_sym2iq #(
  parameter int AMP = 1023,
  parameter int IQW = 11
) (
  input  logic [1:0]            sym_i,
  output logic signed [IQW-1:0] ar_o,
  output logic signed [IQW-1:0] ai_o
);

  localparam logic signed [IQW-1:0] POS = IQW'(AMP);
  localparam logic signed [IQW-1:0] NEG = IQW'(-AMP);

  assign ar_o = sym_i[1] ? NEG : POS;
  assign ai_o = sym_i[0] ? NEG : POS;

endmodule

// File: rtl/iqmap_qpsk.sv
// QPSK transmit mapper: 128-bit words -> 64 I/Q samples, LSB pair first, with a
// one-word holding buffer for gapless streaming. Optional preamble: IQMAP_PREAMBLE_EN.
module iqmap_qpsk
  import qpsk_pkg::*;
#(
  parameter int AMP     = 1023,
  parameter int IQW     = 11,
  parameter int PRE_LEN = 8
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  valid_i,
  input  logic [WORD_W-1:0]     data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic signed [IQW-1:0] ar_o,
  output logic signed [IQW-1:0] ai_o,
  output logic [1:0]            raw_o,
  output logic                  last_o
);

  state_e                state_q, state_d;
  logic [5:0]            sym_cnt_q, sym_cnt_d;
  logic [WORD_W-1:0]     sh_q, sh_d;
  logic [WORD_W-1:0]     hb_q, hb_d;
  logic                  hb_full_q, hb_full_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [1:0]            raw_q, raw_d;
  logic signed [IQW-1:0] ar_q, ar_d;
  logic signed [IQW-1:0] ai_q, ai_d;

  logic                  accept;
  logic                  sym_last;
  logic [1:0]            sym_sel;
  logic signed [IQW-1:0] map_ar, map_ai;

`ifdef IQMAP_PREAMBLE_EN
  localparam int PCW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  logic [PCW-1:0] pre_cnt_q, pre_cnt_d;
  logic           pre_done;

  assign pre_done = (pre_cnt_q == PCW'(PRE_LEN - 1));
  assign sym_sel  = (state_q == ST_PRE) ? pre_sym(pre_cnt_q[0]) : sh_q[1:0];
`else
  assign sym_sel  = sh_q[1:0];
`endif

  assign accept   = ce & valid_i & ~hb_full_q;
  assign sym_last = (sym_cnt_q == 6'(SYMS_PER_WORD - 1));
  assign ready_o  = ~hb_full_q;

  qpsk_sym2iq #(.AMP(AMP), .IQW(IQW)) u_map (
    .sym_i (sym_sel),
    .ar_o  (map_ar),
    .ai_o  (map_ai)
  );

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    sh_d      = sh_q;
    hb_d      = hb_q;
    hb_full_d = hb_full_q;
    valid_d   = valid_q;
    last_d    = last_q;
    raw_d     = raw_q;
    ar_d      = ar_q;
    ai_d      = ai_q;
`ifdef IQMAP_PREAMBLE_EN
    pre_cnt_d = pre_cnt_q;
`endif
    if (ce) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
      raw_d   = '0;
      ar_d    = '0;
      ai_d    = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sh_d      = data_i;
            sym_cnt_d = '0;
`ifdef IQMAP_PREAMBLE_EN
            pre_cnt_d = '0;
            state_d   = ST_PRE;
`else
            state_d   = ST_SEND;
`endif
          end
        end
`ifdef IQMAP_PREAMBLE_EN
        ST_PRE: begin
          valid_d   = 1'b1;
          raw_d     = sym_sel;
          ar_d      = map_ar;
          ai_d      = map_ai;
          pre_cnt_d = pre_cnt_q + PCW'(1);
          if (pre_done) state_d = ST_SEND;
          // The first word already sits in sh; anything offered now waits in hb.
          if (accept) begin
            hb_d      = data_i;
            hb_full_d = 1'b1;
          end
        end
`endif
        ST_SEND: begin
          valid_d   = 1'b1;
          raw_d     = sym_sel;
          ar_d      = map_ar;
          ai_d      = map_ai;
          last_d    = sym_last;
          sh_d      = sh_q >> 2;
          sym_cnt_d = sym_cnt_q + 6'd1;
          if (sym_last) begin
            if (hb_full_q) begin
              sh_d      = hb_q;
              hb_full_d = 1'b0;
            end else if (accept) begin
              sh_d = data_i;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (accept) begin
            hb_d      = data_i;
            hb_full_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      sym_cnt_q <= '0;
      sh_q      <= '0;
      hb_q      <= '0;
      hb_full_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      raw_q     <= '0;
      ar_q      <= '0;
      ai_q      <= '0;
`ifdef IQMAP_PREAMBLE_EN
      pre_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      sh_q      <= sh_d;
      hb_q      <= hb_d;
      hb_full_q <= hb_full_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      raw_q     <= raw_d;
      ar_q      <= ar_d;
      ai_q      <= ai_d;
`ifdef IQMAP_PREAMBLE_EN
      pre_cnt_q <= pre_cnt_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign last_o  = last_q;
  assign raw_o   = raw_q;
  assign ar_o    = ar_q;
  assign ai_o    = ai_q;

endmodule

// File: tb/tb_iqmap_qpsk.sv
// Bench for iqmap_qpsk: directed scenarios plus random traffic against a
// symbol-queue reference model; also recovers each word from the I/Q signs.
module tb_iqmap_qpsk;

  localparam int AMP     = 1023;
  localparam int IQW     = 11;
  localparam int PRE_LEN = 8;
`ifdef IQMAP_PREAMBLE_EN
  localparam int PRE = PRE_LEN;
`else
  localparam int PRE = 0;
`endif

  logic           ck = 1'b0;
  logic           rst = 1'b0;
  logic           ce = 1'b0;
  logic           valid_i = 1'b0;
  logic [127:0]   data_i = '0;
  logic           ready_o, valid_o, last_o;
  logic [IQW-1:0] ar_o, ai_o;
  logic [1:0]     raw_o;

  always #5 ck = ~ck;

  iqmap_qpsk #(.AMP(AMP), .IQW(IQW), .PRE_LEN(PRE_LEN)) dut (
    .ck      (ck),
    .rst     (rst),
    .ce      (ce),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .ar_o    (ar_o),
    .ai_o    (ai_o),
    .raw_o   (raw_o),
    .last_o  (last_o)
  );

  typedef struct packed {
    logic [1:0] raw;
    logic       last;
    logic       pay;
  } sym_t;

  sym_t         q[$];
  logic [127:0] words[$];
  int           pending;
  sym_t         cur;
  logic         cur_v;
  logic [127:0] rec;
  int           rec_k;
  int           n_chk = 0;
  int           n_pass = 0;
  int           n_valid;
  int           last_at[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_word(input logic [127:0] w, input logic from_idle);
    if (from_idle)
      for (int i = 0; i < PRE; i++) q.push_back('{raw: (i % 2) ? 2'b11 : 2'b00, last: 1'b0, pay: 1'b0});
    for (int k = 0; k < 64; k++) q.push_back('{raw: w[2*k +: 2], last: (k == 63), pay: 1'b1});
    words.push_back(w);
    pending++;
  endtask

  task automatic clear_stats();
    n_valid = 0;
    last_at.delete();
  endtask

  // One clock: update the model at the edge, then compare outputs 1 time unit later.
  task automatic tick();
    int             p0;
    logic           acc;
    logic [IQW-1:0] ea, ei;
    @(posedge ck);
    p0  = pending;
    acc = ce && valid_i && (p0 < 2);
    if (ce) begin
      if (q.size() > 0) begin
        cur   = q.pop_front();
        cur_v = 1'b1;
        if (cur.last) pending--;
      end else begin
        cur   = '0;
        cur_v = 1'b0;
      end
      if (acc) push_word(data_i, p0 == 0);
    end
    #1;
    ea = !cur_v ? '0 : (cur.raw[1] ? IQW'(-AMP) : IQW'(AMP));
    ei = !cur_v ? '0 : (cur.raw[0] ? IQW'(-AMP) : IQW'(AMP));
    chk("valid_o", 128'(valid_o), 128'(cur_v));
    chk("raw_o",   128'(raw_o),   128'(cur.raw));
    chk("last_o",  128'(last_o),  128'(cur.last));
    chk("ar_o",    128'(ar_o),    128'(ea));
    chk("ai_o",    128'(ai_o),    128'(ei));
    chk("ready_o", 128'(ready_o), 128'(pending < 2));
    if (ce && valid_o) begin
      n_valid++;
      if (last_o) last_at.push_back(n_valid);
    end
    if (ce && cur_v && cur.pay) begin
      rec[2*rec_k +: 2] = {ar_o[IQW-1], ai_o[IQW-1]};
      rec_k++;
      if (cur.last) begin
        chk("loopback_word", rec, words.pop_front());
        rec_k = 0;
      end
    end
  endtask

  task automatic offer(input logic [127:0] w);
    valid_i = 1'b1;
    data_i  = w;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_valid", 128'(valid_o), 128'(0));
    chk("rst_ar",    128'(ar_o),    128'(0));
    chk("rst_ai",    128'(ai_o),    128'(0));
    chk("rst_raw",   128'(raw_o),   128'(0));
    chk("rst_last",  128'(last_o),  128'(0));
    chk("rst_ready", 128'(ready_o), 128'(1));
    q.delete();
    words.delete();
    pending = 0;
    cur     = '0;
    cur_v   = 1'b0;
    rec     = '0;
    rec_k   = 0;
    @(posedge ck);
    @(posedge ck);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [127:0] w;

    // Reset state, with ce low to show reset ignores it.
    do_reset();
    ce = 1'b1;

    // All-zero word: 64 samples of (+AMP,+AMP), last on the 64th.
    clear_stats();
    offer(128'h0);
    repeat (65 + PRE) tick();
    chk("t1_nvalid", 128'(n_valid), 128'(64 + PRE));
    chk("t1_nlast",  128'(last_at.size()), 128'(1));
    chk("t1_last_at", 128'(last_at[0]), 128'(64 + PRE));

    // Low byte E4 -> raw 00,01,10,11 then random remainder.
    w = {$urandom(), $urandom(), $urandom(), $urandom()};
    w[7:0] = 8'hE4;
    offer(w);
    repeat (66 + PRE) tick();

    // Back-to-back words, second offered 5 cycles after the first.
    clear_stats();
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (4) tick();
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (130 + PRE) tick();
    chk("t3_nvalid",   128'(n_valid), 128'(128 + PRE));
    chk("t3_nlast",    128'(last_at.size()), 128'(2));
    chk("t3_last_at0", 128'(last_at[0]), 128'(64 + PRE));
    chk("t3_last_at1", 128'(last_at[1]), 128'(128 + PRE));

    // Clock enable held low for 10 cycles mid-word.
    clear_stats();
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (30 + PRE) tick();
    ce = 1'b0;
    repeat (10) tick();
    ce = 1'b1;
    repeat (40) tick();
    chk("t4_nvalid", 128'(n_valid), 128'(64 + PRE));

    // Reset mid-burst with the holding buffer full.
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (10) tick();
    offer({$urandom(), $urandom(), $urandom(), $urandom()});
    repeat (9) tick();
    chk("t5_ready_before", 128'(ready_o), 128'(0));
    do_reset();
    clear_stats();
    repeat (70) tick();
    chk("t5_nvalid_after", 128'(n_valid), 128'(0));

    // Random traffic: ce gaps, valid_i offered regardless of ready_o.
    for (int i = 0; i < 400; i++) begin
      ce      = ($urandom_range(0, 9) != 0);
      valid_i = ($urandom_range(0, 3) == 0);
      data_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    ce      = 1'b1;
    valid_i = 1'b0;
    repeat (200) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
